// File: rtl/mem_copy_engine.sv
// ============================================================================
// Module      : mem_copy_engine
// Description : Word-by-word memory copy master (READ/WRITE pair per word).
//               Optional running checksum enabled by MEM_COPY_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_copy_engine #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          mem_address,
    output logic [31:0]          mem_write_data,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic [31:0]          mem_read_data,
    output logic [31:0]          checksum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [LEN_WIDTH-1:0] c_LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] c_LEN_ZERO = '0;

    state_t                 r_state;
    logic [31:0]            r_src_ptr;
    logic [31:0]            r_dst_ptr;
    logic [LEN_WIDTH-1:0]   r_remaining;
    logic [31:0]            r_data_buf;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_mem_read;
    logic                   r_mem_write;
    logic [31:0]            r_mem_address;

    // Outputs are registered for the state being entered, so each arm sets
    // the strobes and address that the next state presents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_src_ptr     <= '0;
            r_dst_ptr     <= '0;
            r_remaining   <= '0;
            r_data_buf    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
        end else begin
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src_ptr   <= src_addr;
                        r_dst_ptr   <= dst_addr;
                        r_remaining <= len;
                        if (len != c_LEN_ZERO) begin
                            r_state       <= S_READ;
                            r_busy        <= 1'b1;
                            r_mem_read    <= 1'b1;
                            r_mem_address <= src_addr;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    r_data_buf    <= mem_read_data;
                    r_state       <= S_WRITE;
                    r_busy        <= 1'b1;
                    r_mem_write   <= 1'b1;
                    r_mem_address <= r_dst_ptr;
                end
                S_WRITE: begin
                    r_src_ptr   <= r_src_ptr + 32'd1;
                    r_dst_ptr   <= r_dst_ptr + 32'd1;
                    r_remaining <= r_remaining - c_LEN_ONE;
                    if (r_remaining == c_LEN_ONE) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state       <= S_READ;
                        r_busy        <= 1'b1;
                        r_mem_read    <= 1'b1;
                        r_mem_address <= r_src_ptr + 32'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_write ? r_data_buf : 32'd0;

`ifdef MEM_COPY_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_checksum <= '0;
        end else if (r_state == S_WRITE) begin
            r_checksum <= r_checksum + r_data_buf;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
// ============================================================================
// Module      : tb_mem_copy_engine
// Description : Directed self-checking bench for mem_copy_engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_copy_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;
    logic [31:0] checksum;

    logic [31:0] mem [0:65535];
    logic        pl_en;
    logic [15:0] pl_addr;
    logic [31:0] pl_data;

    int checks;
    int errors;

    mem_copy_engine #(.LEN_WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .len            (len),
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data),
        .checksum       (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[15:0]];

    // Single writer for the memory: DUT writes, or bench preloads while idle.
    always @(posedge clk) begin
        if (mem_write)
            mem[mem_address[15:0]] <= mem_write_data;
        else if (pl_en)
            mem[pl_addr] <= pl_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    // Drives start across edge 0; returns in cycle 1.
    task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = n;
        tick();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, mem_read, mem_write} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, mem_read, mem_write});
        end
        checks++;
        if (mem_address !== 32'd0 || mem_write_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_bus: addr %h wdata %h expected 0", mem_address, mem_write_data);
        end
        checks++;
        if (checksum !== 32'd0) begin
            errors++;
            $display("FAIL reset_checksum: got %h expected 0", checksum);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_copy();
        logic [3:0]  e_ctrl;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        int          i;
        for (int k = 0; k < 4; k++) preload(16'(2 + k), 32'(k + 1));
        for (int k = 0; k < 4; k++) preload(16'(100 + k), 32'h0);
        launch(32'd2, 32'd100, 16'd4);
        for (int c = 1; c <= 10; c++) begin
            i      = (c - 1) / 2;
            e_ctrl = {c <= 8, c == 9, (c <= 8) && (c % 2 == 1), (c <= 8) && (c % 2 == 0)};
            e_addr = e_ctrl[1] ? 32'(2 + i) : e_ctrl[0] ? 32'(100 + i) : 32'd0;
            e_wd   = e_ctrl[0] ? 32'(i + 1) : 32'd0;
            checks++;
            if ({busy, done, mem_read, mem_write} !== e_ctrl) begin
                errors++;
                $display("FAIL basic_ctrl c%0d: got %b expected %b", c, {busy, done, mem_read, mem_write}, e_ctrl);
            end
            checks++;
            if (mem_address !== e_addr || mem_write_data !== e_wd) begin
                errors++;
                $display("FAIL basic_bus c%0d: addr %h wdata %h expected %h %h", c, mem_address, mem_write_data, e_addr, e_wd);
            end
            if (c == 9) begin
                checks++;
`ifdef MEM_COPY_CHECKSUM_EN
                if (checksum !== 32'd10) begin
`else
                if (checksum !== 32'd0) begin
`endif
                    errors++;
                    $display("FAIL basic_checksum: got %h", checksum);
                end
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[100 + k] !== 32'(k + 1)) begin
                errors++;
                $display("FAIL basic_mem[%0d]: got %h expected %h", 100 + k, mem[100 + k], k + 1);
            end
        end
    endtask

    task automatic test_zero_len();
        int strobes;
        int done_cycle;
        strobes    = 0;
        done_cycle = -1;
        preload(16'd9, 32'h0000_0099);
        launch(32'd7, 32'd9, 16'd0);
        for (int c = 1; c <= 4; c++) begin
            if (mem_read || mem_write || busy) strobes++;
            if (done && done_cycle < 0) done_cycle = c;
            tick();
        end
        checks++;
        if (strobes !== 0) begin
            errors++;
            $display("FAIL zero_strobes: got %0d active cycles expected 0", strobes);
        end
        checks++;
        if (done_cycle !== 1) begin
            errors++;
            $display("FAIL zero_done_cycle: got %0d expected 1", done_cycle);
        end
        checks++;
        if (mem[9] !== 32'h0000_0099) begin
            errors++;
            $display("FAIL zero_mem: got %h expected 00000099", mem[9]);
        end
    endtask

    task automatic test_start_ignored();
        int dones;
        int done_cycle;
        int stray;
        dones      = 0;
        done_cycle = -1;
        stray      = 0;
        for (int k = 0; k < 4; k++) preload(16'(100 + k), 32'h0);
        preload(16'd104, 32'h0000_00AA);
        preload(16'd300, 32'h0000_00BB);
        launch(32'd2, 32'd100, 16'd4);
        for (int c = 1; c <= 25; c++) begin
            if (done) begin
                dones++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (mem_write && (mem_address < 32'd100 || mem_address > 32'd103)) stray++;
            start    = (c == 3);
            src_addr = 32'd200;
            dst_addr = 32'd300;
            len      = 16'd10;
            tick();
        end
        start = 1'b0;
        checks++;
        if (dones !== 1 || done_cycle !== 9) begin
            errors++;
            $display("FAIL ignored_done: got %0d pulses first at %0d expected 1 at 9", dones, done_cycle);
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL ignored_stray_writes: got %0d expected 0", stray);
        end
        checks++;
        if (mem[103] !== 32'd4 || mem[104] !== 32'h0000_00AA || mem[300] !== 32'h0000_00BB) begin
            errors++;
            $display("FAIL ignored_mem: got %h %h %h expected 4 aa bb", mem[103], mem[104], mem[300]);
        end
    endtask

    task automatic test_mid_reset();
        int dones;
        dones = 0;
        for (int k = 0; k < 4; k++) preload(16'(100 + k), 32'h0);
        preload(16'd110, 32'h0);
        launch(32'd2, 32'd100, 16'd4);
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, done, mem_read, mem_write} !== 4'b0000 || mem_address !== 32'd0
            || mem_write_data !== 32'd0 || checksum !== 32'd0) begin
            errors++;
            $display("FAIL midrst_outputs: ctrl %b addr %h wdata %h sum %h expected all 0",
                     {busy, done, mem_read, mem_write}, mem_address, mem_write_data, checksum);
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (done || busy) dones++;
            tick();
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL midrst_activity: got %0d active cycles expected 0", dones);
        end
        checks++;
        if (mem[100] !== 32'd1 || mem[101] !== 32'd0 || mem[102] !== 32'd0 || mem[103] !== 32'd0) begin
            errors++;
            $display("FAIL midrst_mem: got %h %h %h %h expected 1 0 0 0", mem[100], mem[101], mem[102], mem[103]);
        end
        launch(32'd5, 32'd110, 16'd1);
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'd5) begin
            errors++;
            $display("FAIL midrst_restart_read: rd %b addr %h expected 1 00000005", mem_read, mem_address);
        end
        tick();
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL midrst_restart_done: got %b expected 1", done);
        end
        tick();
        checks++;
        if (mem[110] !== 32'd4) begin
            errors++;
            $display("FAIL midrst_restart_mem: got %h expected 4", mem[110]);
        end
    endtask

    task automatic test_wrap_checksum();
        logic [31:0] e_sum;
`ifdef MEM_COPY_CHECKSUM_EN
        e_sum = 32'd1;
`else
        e_sum = 32'd0;
`endif
        preload(16'hFFFF, 32'hFFFF_FFFF);
        preload(16'h0000, 32'h0000_0002);
        preload(16'h0010, 32'h0);
        preload(16'h0011, 32'h0);
        launch(32'hFFFF_FFFF, 32'h0000_0010, 16'd2);
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_rd0: rd %b addr %h expected 1 ffffffff", mem_read, mem_address);
        end
        tick();
        checks++;
        if (mem_write !== 1'b1 || mem_address !== 32'h10 || mem_write_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_wr0: wr %b addr %h data %h expected 1 10 ffffffff", mem_write, mem_address, mem_write_data);
        end
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 32'h0) begin
            errors++;
            $display("FAIL wrap_rd1: rd %b addr %h expected 1 0", mem_read, mem_address);
        end
        tick();
        checks++;
        if (mem_write !== 1'b1 || mem_address !== 32'h11 || mem_write_data !== 32'h2) begin
            errors++;
            $display("FAIL wrap_wr1: wr %b addr %h data %h expected 1 11 2", mem_write, mem_address, mem_write_data);
        end
        tick();
        checks++;
        if (done !== 1'b1 || checksum !== e_sum) begin
            errors++;
            $display("FAIL wrap_done_sum: done %b sum %h expected 1 %h", done, checksum, e_sum);
        end
        tick();
        tick();
        checks++;
        if (checksum !== e_sum || mem[16'h10] !== 32'hFFFF_FFFF || mem[16'h11] !== 32'h2) begin
            errors++;
            $display("FAIL wrap_final: sum %h mem %h %h expected %h ffffffff 2", checksum, mem[16'h10], mem[16'h11], e_sum);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        src_addr = 32'd0;
        dst_addr = 32'd0;
        len      = 16'd0;
        pl_en    = 1'b0;
        pl_addr  = 16'd0;
        pl_data  = 32'd0;
        #2;
        test_reset();
        test_basic_copy();
        test_zero_len();
        test_start_ignored();
        test_mid_reset();
        test_wrap_checksum();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
